index_stream_tx: RTL and testbench
==================================

// Module: index_stream_tx
// PURPOSE
//  Transmit side of the loop-index interface. Accepts a loop length over a valid/ready load port.
//  Emits one index beat per step over a valid/ready stream, with a last flag on the final beat.
//  Downstream back-pressure (out_ready low) stalls stepping, like the receive-side counter's stop input.
//  Sits in the fused-block controller and feeds loop indices to the address generators.
// PARAMETERS
//  WIDTH    4   index and length width in bits; load_len = 0 is a legal empty loop
// PORTS
//  clk        in   1      clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  flush      in   1      synchronous abort; returns the block to IDLE
//  load_valid in   1      load_len is valid
//  load_ready out  1      block can accept a new length; high only in IDLE
//  load_len   in   WIDTH  number of beats to emit (0..2^WIDTH-1)
//  out_valid  out  1      out_index / out_last are valid
//  out_ready  in   1      downstream accepts the beat; low = stall
//  out_index  out  WIDTH  current loop index
//  out_last   out  1      beat is the final one of the loop
//  done       out  1      one-cycle pulse after the last beat is accepted or an empty loop is taken
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_index=0, out_last=0, done=0, busy=0, load_ready=1.
//  All outputs are registered except load_ready and busy, which decode the state.
//  States: IDLE, RUN.
//  IDLE, load_valid=1, len>0: latch len; next cycle RUN with out_valid=1, index=0, last=(len==1).
//  IDLE, load_valid=1, len=0: stay in IDLE; done=1 next cycle; no beat is emitted.
//  RUN: a beat transfers when out_valid && out_ready.
//    On transfer, index advances by 1 and last=(new index==len-1).
//  RUN, out_ready=0: out_valid, out_index and out_last hold stable; no change allowed while stalled.
//  RUN, transfer with out_last=1: next cycle IDLE, out_valid=0, done=1 for exactly one cycle.
//  Throughput: 1 beat/cycle while out_ready=1.
//    One bubble cycle between loops: IDLE is re-entered before the next load is accepted.
//  The length register is frozen in RUN; load_valid is ignored there (load_ready=0).
//  flush has priority over everything except reset.
//    Next cycle IDLE, out_valid=0, out_last=0, done=0.
//    A flush in the same cycle as a last transfer suppresses done.
//  Reset mid-loop: immediately returns to the reset values; the loop is lost.
//  Index arithmetic is WIDTH bits. It never wraps, because len is at most 2^WIDTH-1.
// CONFIGURATION
//  `INDEX_STREAM_DESCEND_EN defined: indices run len-1 down to 0.
//    last=(index==0); the first beat carries len-1.
//  Not defined: ascending order 0..len-1 (default).
//  Handshake, latency and done timing are identical in both modes.
// STRUCTURE
//  Package idx_stream_pkg holds:
//    typedef enum logic {IDLE, RUN} idx_state_e;
//    localparam for the default WIDTH.
//  No sub-module: a single always_ff for state/length/index and a small combinational next-state block.
// TESTING
//  Load len=4, out_ready=1 -> indices 0,1,2,3 on 4 consecutive cycles; last on 3; done 1 cycle after.
//  Load len=3, out_ready low 2 cycles at beat 1 -> index 1 held stable 3 cycles; total 5 beat-cycles.
//  Load len=0 -> no out_valid; done pulses the next cycle; load_ready stays 1.
//  Load len=5, flush asserted during beat 2 -> out_valid=0 next cycle, no done, new load accepted.
//  Load len=15 (WIDTH=4) -> indices 0..14 with no wrap; last only on 14.
//  DESCEND_EN build, len=3 -> indices 2,1,0, with last on 0.
//  Reset_n low during RUN -> all outputs equal their reset values asynchronously.

Source files
------------

// File: rtl/index_stream_tx_pkg.sv
// ---------------------------------------------------------------------------
// idx_stream_pkg
// Shared types and defaults for the loop-index stream transmitter.
//   idx_state_e       : controller state (IDLE / RUN)
//   IDX_WIDTH_DEFAULT : default index / length width in bits
// ---------------------------------------------------------------------------
package idx_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } idx_state_e;

    localparam int unsigned IDX_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/index_stream_tx.sv
// ---------------------------------------------------------------------------
// index_stream_tx
// Transmit side of the loop-index interface. A loop length is accepted on a
// valid/ready load port and one index beat per step is emitted on a
// valid/ready stream, with a last flag on the final beat. Back-pressure on
// out_ready stalls stepping.
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   flush       in   synchronous abort back to IDLE (highest priority)
//   load_valid  in   load_len is valid
//   load_ready  out  a new length can be accepted (IDLE only)
//   load_len    in   number of beats to emit, 0 is an empty loop
//   out_valid   out  out_index / out_last are valid
//   out_ready   in   downstream accepts the beat
//   out_index   out  current loop index
//   out_last    out  final beat of the loop
//   done        out  one-cycle pulse after the last beat or an empty loop
//   busy        out  block is not IDLE
//
// Configuration
//   INDEX_STREAM_DESCEND_EN : when defined indices run len-1 down to 0,
//                             otherwise 0 up to len-1. Handshake and timing
//                             are identical in both modes.
// ---------------------------------------------------------------------------
module index_stream_tx
    import idx_stream_pkg::*;
#(
    parameter int unsigned WIDTH = IDX_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_index,
    output logic             out_last,
    output logic             done,
    output logic             busy
);

    idx_state_e       r_state;
    logic [WIDTH-1:0] r_len;
    logic [WIDTH-1:0] r_index;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_done;

    idx_state_e       w_state_nxt;
    logic [WIDTH-1:0] w_len_nxt;
    logic [WIDTH-1:0] w_index_nxt;
    logic             w_out_valid_nxt;
    logic             w_out_last_nxt;
    logic             w_done_nxt;

    logic [WIDTH-1:0] w_first_index;
    logic [WIDTH-1:0] w_step_index;
    logic             w_step_is_last;

`ifdef INDEX_STREAM_DESCEND_EN
    // Descending: start at len-1, count down, last beat carries index 0.
    assign w_first_index  = load_len - WIDTH'(1);
    assign w_step_index   = r_index - WIDTH'(1);
    assign w_step_is_last = (w_step_index == '0);
`else
    // Ascending: start at 0, count up, last beat carries len-1.
    assign w_first_index  = '0;
    assign w_step_index   = r_index + WIDTH'(1);
    assign w_step_is_last = (w_step_index == (r_len - WIDTH'(1)));
`endif

    // Next-state and registered-output computation.
    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_index_nxt     = r_index;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_done_nxt      = 1'b0;

        if (flush) begin
            // Abort wins over any load or transfer, including the last one,
            // so done is suppressed.
            w_state_nxt     = IDLE;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        if (load_len != '0) begin
                            w_state_nxt     = RUN;
                            w_len_nxt       = load_len;
                            w_index_nxt     = w_first_index;
                            w_out_valid_nxt = 1'b1;
                            w_out_last_nxt  = (load_len == WIDTH'(1));
                        end else begin
                            // Empty loop: no beat, just the completion pulse.
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // out_valid is always high in RUN, so out_ready alone
                    // qualifies a transfer; without it everything holds.
                    if (r_out_valid && out_ready) begin
                        if (r_out_last) begin
                            w_state_nxt     = IDLE;
                            w_out_valid_nxt = 1'b0;
                            w_out_last_nxt  = 1'b0;
                            w_done_nxt      = 1'b1;
                        end else begin
                            w_index_nxt    = w_step_index;
                            w_out_last_nxt = w_step_is_last;
                        end
                    end
                end
                default: begin
                    w_state_nxt     = IDLE;
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_index     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_index     <= w_index_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign load_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign out_valid  = r_out_valid;
    assign out_index  = r_index;
    assign out_last   = r_out_last;
    assign done       = r_done;

endmodule

// File: tb/tb_index_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_index_stream_tx
// Self-checking bench for index_stream_tx. The reference model keeps the
// beats still owed to downstream in a queue: the front entry is the beat on
// the bus, the queue size tells whether the beat is last, and an empty queue
// means the block is idle. Inputs are driven and outputs compared on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_index_stream_tx;

    localparam int unsigned W = 4;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_len;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_index;
    logic         out_last;
    logic         done;
    logic         busy;

    index_stream_tx #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_len   (load_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_last   (out_last),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model: beats still to be emitted, and the expected done level.
    int m_q[$];
    bit m_done = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
        check_val("load_ready", 32'(load_ready), 32'(m_q.size() == 0));
        check_val("busy",       32'(busy),       32'(m_q.size() != 0));
        check_val("done",       32'(done),       32'(m_done));
        if (m_q.size() != 0) begin
            check_val("out_index", 32'(out_index), 32'(m_q[0]));
            check_val("out_last",  32'(out_last),  32'(m_q.size() == 1));
        end
    endtask

    // Called on a falling edge: compare, drive new inputs, advance the model
    // over the next rising edge, then wait for the following falling edge.
    task automatic cycle(input bit lv, input int unsigned len, input bit rdy,
                         input bit fl);
        check_outputs();
        load_valid = lv;
        load_len   = W'(len);
        out_ready  = rdy;
        flush      = fl;
        m_done     = 1'b0;
        if (fl) begin
            m_q.delete();
        end else if (m_q.size() != 0) begin
            if (rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (lv) begin
            if (len == 0) begin
                m_done = 1'b1;
            end else begin
                for (int i = 0; i < int'(len); i++) begin
`ifdef INDEX_STREAM_DESCEND_EN
                    m_q.push_back(int'(len) - 1 - i);
`else
                    m_q.push_back(i);
`endif
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        flush      = 1'b0;
        load_valid = 1'b0;
        load_len   = '0;
        out_ready  = 1'b1;

        // Reset state
        @(negedge clk);
        check_val("rst_out_index", 32'(out_index), 32'd0);
        check_val("rst_out_last",  32'(out_last),  32'd0);
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // len=4, no back-pressure
        cycle(1'b1, 4, 1'b1, 1'b0);
        idle_cycles(6);

        // len=3, out_ready low for two cycles on beat 1
        cycle(1'b1, 3, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        idle_cycles(4);

        // Empty loop
        cycle(1'b1, 0, 1'b1, 1'b0);
        idle_cycles(2);

        // len=5, flush during beat 2, then an immediate new load
        cycle(1'b1, 5, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1);
        cycle(1'b1, 2, 1'b1, 1'b0);
        idle_cycles(4);

        // Flush coincident with last transfer suppresses done
        cycle(1'b1, 1, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1);
        idle_cycles(2);

        // Full-range loop, no wrap
        cycle(1'b1, 15, 1'b1, 1'b0);
        idle_cycles(17);

        // Back-to-back loads with load_valid held high
        for (int i = 0; i < 8; i++) cycle(1'b1, 2, 1'b1, 1'b0);
        idle_cycles(3);

        // Asynchronous reset in the middle of a loop
        cycle(1'b1, 6, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        #2;
        load_valid = 1'b0;
        reset_n    = 1'b0;
        #1;
        m_q.delete();
        m_done = 1'b0;
        check_val("arst_out_index", 32'(out_index), 32'd0);
        check_val("arst_out_last",  32'(out_last),  32'd0);
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          lv;
            int unsigned len;
            bit          rdy;
            bit          fl;
            lv  = ($urandom_range(0, 2) != 0);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2)
                                              : $urandom_range(0, 15);
            rdy = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 59) == 0);
            cycle(lv, len, rdy, fl);
        end
        idle_cycles(20);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
